video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_pkg.sv | 40 ++++
 rtl/vtg_pattern.sv | 45 ++++
 rtl/video_timing_gen.sv | 184 ++++++++++++++++++
 tb/tb_video_timing_gen.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_pkg
// Summary  : Default raster timing, pattern-mode encoding and FSM state type.
// Revision : 1.0
// ============================================================================
package video_timing_pkg;

    localparam int c_def_h_active = 1600;
    localparam int c_def_h_fp     = 48;
    localparam int c_def_h_sync   = 32;
    localparam int c_def_h_bp     = 80;
    localparam int c_def_v_active = 900;
    localparam int c_def_v_fp     = 3;
    localparam int c_def_v_sync   = 5;
    localparam int c_def_v_bp     = 18;

    typedef enum logic [1:0] {
        MODE_HRAMP   = 2'd0,
        MODE_VRAMP   = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_FLAT    = 2'd3
    } vtg_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } vtg_state_e;

    // Counters are never narrower than 8 bits so the ramp patterns can
    // always take the low byte directly.
    function automatic int cnt_width(input int total);
        int w;
        w = $clog2(total);
        return (w < 8) ? 8 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vtg_pattern.sv
`default_nettype none
// ============================================================================
// Module   : vtg_pattern
// Summary  : Combinational luma decode from raster position; VTG_SCROLL_EN adds
//            a frame offset to the ramp patterns.
// Revision : 1.0
// ============================================================================
module vtg_pattern
    import video_timing_pkg::*;
(
    input  logic [7:0] h_i,
    input  logic [7:0] v_i,
    input  vtg_mode_e  mode_i,
    input  logic [7:0] level_i,
`ifdef VTG_SCROLL_EN
    input  logic [7:0] offset_i,
`endif
    output logic [7:0] luma_o
);

    logic [7:0] w_h_ramp;
    logic [7:0] w_v_ramp;

`ifdef VTG_SCROLL_EN
    // 8-bit sum wraps naturally, giving the modulo-256 scroll.
    assign w_h_ramp = h_i + offset_i;
    assign w_v_ramp = v_i + offset_i;
`else
    assign w_h_ramp = h_i;
    assign w_v_ramp = v_i;
`endif

    always_comb begin
        luma_o = 8'h00;
        case (mode_i)
            MODE_HRAMP:   luma_o = w_h_ramp;
            MODE_VRAMP:   luma_o = w_v_ramp;
            MODE_CHECKER: luma_o = (h_i[5] ^ v_i[5]) ? 8'hFF : 8'h00;
            MODE_FLAT:    luma_o = level_i;
            default:      luma_o = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Summary  : Raster timing and test-pattern generator with IDLE/RUN/DRAIN
//            control; define VTG_SCROLL_EN for a per-frame ramp scroll.
// Revision : 1.0
// ============================================================================
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_def_h_active,
    parameter int H_FP     = c_def_h_fp,
    parameter int H_SYNC   = c_def_h_sync,
    parameter int H_BP     = c_def_h_bp,
    parameter int V_ACTIVE = c_def_v_active,
    parameter int V_FP     = c_def_v_fp,
    parameter int V_SYNC   = c_def_v_sync,
    parameter int V_BP     = c_def_v_bp
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode_i,
    input  logic [7:0] level_i,
    output logic [7:0] y_o,
    output logic       dv_o,
    output logic       hs_o,
    output logic       vs_o,
    output logic       sof_o,
    output logic       busy_o
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_hw      = cnt_width(c_h_total);
    localparam int c_vw      = cnt_width(c_v_total);

    localparam logic [c_hw-1:0] c_h_last    = c_hw'(c_h_total - 1);
    localparam logic [c_hw-1:0] c_h_act_end = c_hw'(H_ACTIVE);
    localparam logic [c_hw-1:0] c_hs_begin  = c_hw'(H_ACTIVE + H_FP);
    localparam logic [c_hw-1:0] c_hs_end    = c_hw'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_vw-1:0] c_v_last    = c_vw'(c_v_total - 1);
    localparam logic [c_vw-1:0] c_v_act_end = c_vw'(V_ACTIVE);
    localparam logic [c_vw-1:0] c_vs_begin  = c_vw'(V_ACTIVE + V_FP);
    localparam logic [c_vw-1:0] c_vs_end    = c_vw'(V_ACTIVE + V_FP + V_SYNC);

    vtg_state_e      state_q, state_d;
    logic [c_hw-1:0] h_q, h_d;
    logic [c_vw-1:0] v_q, v_d;
    vtg_mode_e       mode_q;
    logic [7:0]      level_q;

    logic [7:0] y_q;
    logic       dv_q, hs_q, vs_q, sof_q, busy_q;

    logic       w_active;
    logic       w_h_end;
    logic       w_frame_end;
    logic       w_first;
    logic       w_dv, w_hs, w_vs;
    vtg_mode_e  w_mode;
    logic [7:0] w_level;
    logic [7:0] w_luma;

    assign w_active    = (state_q != ST_IDLE);
    assign w_h_end     = (h_q == c_h_last);
    assign w_frame_end = w_h_end && (v_q == c_v_last);
    assign w_first     = (h_q == '0) && (v_q == '0);

    // ------------------------------------------------------------------
    // Control FSM and raster counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;

        case (state_q)
            ST_IDLE:  if (en) state_d = ST_RUN;
            ST_RUN:   if (!en) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (en)               state_d = ST_RUN;
                else if (w_frame_end) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase

        if (!w_active) begin
            h_d = '0;
            v_d = '0;
        end else if (w_h_end) begin
            h_d = '0;
            v_d = (v_q == c_v_last) ? '0 : v_q + c_vw'(1);
        end else begin
            h_d = h_q + c_hw'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    // ------------------------------------------------------------------
    // Pattern selection: the frame's first pixel already uses the newly
    // sampled mode/level, later pixels use the held copy.
    // ------------------------------------------------------------------
    assign w_mode  = w_first ? vtg_mode_e'(mode_i) : mode_q;
    assign w_level = w_first ? level_i : level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_HRAMP;
            level_q <= 8'h00;
        end else if (w_active && w_first) begin
            mode_q  <= vtg_mode_e'(mode_i);
            level_q <= level_i;
        end
    end

`ifdef VTG_SCROLL_EN
    logic [7:0] offset_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            offset_q <= 8'h00;
        end else if (w_active && w_frame_end) begin
            offset_q <= offset_q + 8'd1;
        end
    end
`endif

    vtg_pattern u_pattern (
        .h_i      (h_q[7:0]),
        .v_i      (v_q[7:0]),
        .mode_i   (w_mode),
        .level_i  (w_level),
`ifdef VTG_SCROLL_EN
        .offset_i (offset_q),
`endif
        .luma_o   (w_luma)
    );

    // ------------------------------------------------------------------
    // Registered outputs, one cycle behind the counters they decode
    // ------------------------------------------------------------------
    assign w_dv = w_active && (h_q < c_h_act_end) && (v_q < c_v_act_end);
    assign w_hs = w_active && (h_q >= c_hs_begin) && (h_q < c_hs_end);
    assign w_vs = w_active && (v_q >= c_vs_begin) && (v_q < c_vs_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q    <= 8'h00;
            dv_q   <= 1'b0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            sof_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            y_q    <= w_dv ? w_luma : 8'h00;
            dv_q   <= w_dv;
            hs_q   <= w_hs;
            vs_q   <= w_vs;
            sof_q  <= w_active && w_first;
            busy_q <= w_active;
        end
    end

    assign y_o    = y_q;
    assign dv_o   = dv_q;
    assign hs_o   = hs_q;
    assign vs_o   = vs_q;
    assign sof_o  = sof_q;
    assign busy_o = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_gen
// Summary  : Self-checking bench for video_timing_gen on a reduced raster.
// Revision : 1.0
// ============================================================================
module tb_video_timing_gen;

    localparam int HA = 80, HFP = 4, HS = 6, HBP = 6;
    localparam int VA = 40, VFP = 2, VS = 3, VBP = 3;
    localparam int HT = HA + HFP + HS + HBP;   // 96
    localparam int VT = VA + VFP + VS + VBP;   // 48
    localparam int FT = HT * VT;               // 4608

`ifdef VTG_SCROLL_EN
    localparam bit SCROLL = 1'b1;
`else
    localparam bit SCROLL = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       en      = 1'b0;
    logic [1:0] mode_i  = 2'd0;
    logic [7:0] level_i = 8'h00;
    logic [7:0] y_o;
    logic       dv_o, hs_o, vs_o, sof_o, busy_o;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode_i  (mode_i),
        .level_i (level_i),
        .y_o     (y_o),
        .dv_o    (dv_o),
        .hs_o    (hs_o),
        .vs_o    (vs_o),
        .sof_o   (sof_o),
        .busy_o  (busy_o)
    );

    typedef struct packed {
        logic [7:0] y;
        logic       dv, hs, vs, sof, busy;
    } exp_t;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] level;
        int         h;
        int         v;
        logic [7:0] y;
        logic       dv, hs, vs, sof;
    } vec_t;

    exp_t sbq[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc_no = 0;
    int   pos    = 0;

    int   sb_n   = 0;
    bit   sb_bad = 1'b0;
    exp_t sb_act, sb_exp;
    int   sb_at;

    // Reference model state: frame-relative cycle index plus run flags.
    int         m_t       = 0;
    bit         m_on      = 1'b0;
    bit         m_prev_en = 1'b1;
    logic [1:0] m_mode    = 2'd0;
    logic [7:0] m_level   = 8'h00;
    logic [7:0] m_off     = 8'h00;

    function automatic logic [7:0] pix(input logic [1:0] md, input logic [7:0] lv,
                                       input int h, input int v, input logic [7:0] off);
        int s;
        s = SCROLL ? int'(off) : 0;
        case (md)
            2'd0:    return 8'((h + s) % 256);
            2'd1:    return 8'((v + s) % 256);
            2'd2:    return (((h / 32) % 2) != ((v / 32) % 2)) ? 8'hFF : 8'h00;
            default: return lv;
        endcase
    endfunction

    task automatic model_step(output exp_t e);
        int         h, v;
        logic [1:0] md;
        logic [7:0] lv;
        h = m_t % HT;
        v = m_t / HT;
        e = '0;
        if (rst) begin
            m_on  = 1'b0;
            m_t   = 0;
            m_off = 8'h00;
            return;
        end
        if (m_on) begin
            md = (m_t == 0) ? mode_i  : m_mode;
            lv = (m_t == 0) ? level_i : m_level;
            if (m_t == 0) begin
                m_mode  = mode_i;
                m_level = level_i;
            end
            e.busy = 1'b1;
            e.dv   = (h < HA) && (v < VA);
            e.hs   = (h >= HA + HFP) && (h < HA + HFP + HS);
            e.vs   = (v >= VA + VFP) && (v < VA + VFP + VS);
            e.sof  = (m_t == 0);
            e.y    = e.dv ? pix(md, lv, h, v, m_off) : 8'h00;
            if (m_t == FT - 1) begin
                m_off = m_off + 8'd1;
                // Draining (en low last cycle) and still low: generator stops.
                if (!m_prev_en && !en) m_on = 1'b0;
            end
            m_t = (m_t + 1) % FT;
        end else if (en) begin
            m_on = 1'b1;
            m_t  = 0;
        end
        m_prev_en = en;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_flush();
        if (sb_n == 0) return;
        n_vec++;
        if (sb_bad) begin
            n_fail++;
            $display("FAIL sb_window@cycle%0d: got y=%02h dv/hs/vs/sof/busy=%05b, expected y=%02h %05b",
                     sb_at, sb_act.y, sb_act[4:0], sb_exp.y, sb_exp[4:0]);
        end
        sb_n   = 0;
        sb_bad = 1'b0;
    endtask

    task automatic sb_check();
        exp_t a, e;
        if (sbq.size() == 0) return;
        a = {y_o, dv_o, hs_o, vs_o, sof_o, busy_o};
        e = sbq.pop_front();
        if (a !== e && !sb_bad) begin
            sb_bad = 1'b1;
            sb_act = a;
            sb_exp = e;
            sb_at  = cyc_no;
        end
        sb_n++;
        if (sb_n == 64) sb_flush();
    endtask

    task automatic cyc();
        exp_t e;
        model_step(e);
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cyc_no++;
        pos++;
        sb_check();
    endtask

    task automatic wait_sof(input int limit, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!sof_o && n < limit);
    endtask

    task automatic restart(input logic [1:0] md, input logic [7:0] lv);
        int n;
        rst = 1'b1;
        cyc();
        chk("rst_outputs_zero", 32'({y_o, dv_o, hs_o, vs_o, sof_o, busy_o}), 32'd0);
        rst     = 1'b0;
        en      = 1'b1;
        mode_i  = md;
        level_i = lv;
        wait_sof(10, n);
        chk("rst_release_to_first_dv", 32'(n), 32'd2);
        pos = 0;
    endtask

    localparam int NV = 27;

    initial begin
        vec_t tv[NV];
        int   cur_mode, tgt, n;
        int   c_dv, c_hs, c_vs, c_sof;

        // mode, level, h, v, y, dv, hs, vs, sof
        tv[0]  = '{2'd2, 8'h00,  0,  0, 8'h00, 1, 0, 0, 1};
        tv[1]  = '{2'd2, 8'h00, 31,  0, 8'h00, 1, 0, 0, 0};
        tv[2]  = '{2'd2, 8'h00, 32,  0, 8'hFF, 1, 0, 0, 0};
        tv[3]  = '{2'd2, 8'h00, 63,  0, 8'hFF, 1, 0, 0, 0};
        tv[4]  = '{2'd2, 8'h00, 64,  0, 8'h00, 1, 0, 0, 0};
        tv[5]  = '{2'd2, 8'h00, 80,  0, 8'h00, 0, 0, 0, 0};
        tv[6]  = '{2'd2, 8'h00, 83,  5, 8'h00, 0, 0, 0, 0};
        tv[7]  = '{2'd2, 8'h00, 84,  5, 8'h00, 0, 1, 0, 0};
        tv[8]  = '{2'd2, 8'h00, 89,  5, 8'h00, 0, 1, 0, 0};
        tv[9]  = '{2'd2, 8'h00, 90,  5, 8'h00, 0, 0, 0, 0};
        tv[10] = '{2'd2, 8'h00,  0, 32, 8'hFF, 1, 0, 0, 0};
        tv[11] = '{2'd2, 8'h00, 32, 32, 8'h00, 1, 0, 0, 0};
        tv[12] = '{2'd2, 8'h00, 79, 39, 8'hFF, 1, 0, 0, 0};
        tv[13] = '{2'd2, 8'h00,  0, 41, 8'h00, 0, 0, 0, 0};
        tv[14] = '{2'd2, 8'h00,  0, 42, 8'h00, 0, 0, 1, 0};
        tv[15] = '{2'd2, 8'h00, 86, 43, 8'h00, 0, 1, 1, 0};
        tv[16] = '{2'd2, 8'h00, 95, 44, 8'h00, 0, 0, 1, 0};
        tv[17] = '{2'd2, 8'h00,  0, 45, 8'h00, 0, 0, 0, 0};
        tv[18] = '{2'd0, 8'h00,  0,  0, 8'h00, 1, 0, 0, 1};
        tv[19] = '{2'd0, 8'h00,  5,  3, 8'h05, 1, 0, 0, 0};
        tv[20] = '{2'd0, 8'h00, 79, 10, 8'h4F, 1, 0, 0, 0};
        tv[21] = '{2'd0, 8'h00, 40, 39, 8'h28, 1, 0, 0, 0};
        tv[22] = '{2'd1, 8'h00,  0, 20, 8'h14, 1, 0, 0, 0};
        tv[23] = '{2'd1, 8'h00, 10, 39, 8'h27, 1, 0, 0, 0};
        tv[24] = '{2'd3, 8'h5A, 79,  0, 8'h5A, 1, 0, 0, 0};
        tv[25] = '{2'd3, 8'h5A, 80,  0, 8'h00, 0, 0, 0, 0};
        tv[26] = '{2'd3, 8'h5A, 17, 20, 8'h5A, 1, 0, 0, 0};

        // ---------------- table-driven pixel/sync vectors ----------------
        cur_mode = -1;
        for (int i = 0; i < NV; i++) begin
            tgt = tv[i].v * HT + tv[i].h;
            if (int'(tv[i].mode) != cur_mode || tgt < pos) begin
                restart(tv[i].mode, tv[i].level);
                cur_mode = int'(tv[i].mode);
            end
            while (pos < tgt) cyc();
            chk($sformatf("vec%0d_m%0d_(%0d,%0d)", i, tv[i].mode, tv[i].h, tv[i].v),
                32'({y_o, dv_o, hs_o, vs_o, sof_o}),
                32'({tv[i].y, tv[i].dv, tv[i].hs, tv[i].vs, tv[i].sof}));
        end

        // ---------------- free run: per-frame counts and period ----------
        restart(2'd0, 8'h00);
        c_dv = int'(dv_o); c_hs = int'(hs_o); c_vs = int'(vs_o); c_sof = int'(sof_o);
        n = 0;
        do begin
            cyc();
            n++;
            if (!sof_o) begin
                c_dv += int'(dv_o); c_hs += int'(hs_o); c_vs += int'(vs_o);
            end
        end while (!sof_o && n < 2 * FT);
        chk("frame_period", 32'(n), 32'(FT));
        chk("frame_dv_count", 32'(c_dv), 32'(HA * VA));
        chk("frame_hs_count", 32'(c_hs), 32'(HS * VT));
        chk("frame_vs_count", 32'(c_vs), 32'(VS * HT));
        chk("frame_sof_count", 32'(c_sof), 32'd1);

        // ---------------- mid-frame mode change + en glitch --------------
        restart(2'd0, 8'h00);
        while (pos < 10 * HT) cyc();
        mode_i  = 2'd3;
        level_i = 8'h80;
        en      = 1'b0;
        repeat (3) cyc();
        en = 1'b1;
        while (pos < 20 * HT + 5) cyc();
        chk("mode_change_same_frame_y", 32'(y_o), 32'h05);
        wait_sof(2 * FT, n);
        chk("mode_change_next_sof", 32'(sof_o), 32'd1);
        chk("mode_change_next_frame_px0", 32'(y_o), 32'h80);
        pos = 0;
        while (pos < 20 * HT + 5) cyc();
        chk("mode_change_next_frame_px", 32'(y_o), 32'h80);

        // ---------------- en drop mid-frame drains the frame -------------
        restart(2'd0, 8'h00);
        c_dv = int'(dv_o);
        while (pos < 20 * HT) begin
            cyc();
            c_dv += int'(dv_o);
        end
        en = 1'b0;
        while (busy_o && pos < 2 * FT) begin
            cyc();
            c_dv += int'(dv_o);
        end
        chk("drain_dv_count", 32'(c_dv), 32'(HA * VA));
        chk("drain_idle_at_frame_end", 32'(pos), 32'(FT));
        repeat (5) cyc();
        chk("drain_idle_outputs", 32'({y_o, dv_o, hs_o, vs_o, sof_o, busy_o}), 32'd0);
        en = 1'b1;
        wait_sof(10, n);
        chk("drain_restart_latency", 32'(n), 32'd2);
        chk("drain_restart_dv", 32'(dv_o), 32'd1);

        // ---------------- reset mid-frame, then scroll over frames -------
        restart(2'd0, 8'h00);
        while (pos < 30 * HT + 7) cyc();
        rst = 1'b1;
        cyc();
        chk("midframe_rst_outputs", 32'({y_o, dv_o, hs_o, vs_o, sof_o, busy_o}), 32'd0);
        rst = 1'b0;
        wait_sof(10, n);
        chk("midframe_rst_restart_latency", 32'(n), 32'd2);
        chk("scroll_frame0_px0", 32'(y_o), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            wait_sof(FT + 10, n);
            chk($sformatf("scroll_frame%0d_period", k), 32'(n), 32'(FT));
            chk($sformatf("scroll_frame%0d_px0", k), 32'(y_o), SCROLL ? 32'(k) : 32'd0);
        end

        sb_flush();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
